redun_collapse: RTL and testbench
=================================

REDUN_COLLAPSE -- requirements
Module: redun_collapse

Interface
REQ-001 The block SHALL have no parameters; NUM_WRDS, WRD_BITS and P SHALL come from redun_mont_pkg.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_mul  input  redun0_t  redundant squarer result: NUM_WRDS words of WRD_BITS+1 bits, top bit is a carry.
REQ-005 i_val  input  1  single-cycle strobe qualifying i_mul; there is no input back-pressure.
REQ-006 o_busy  input-side status  output  1  high whenever the capture buffer is occupied.
REQ-007 o_dat  output  NUM_WRDS*WRD_BITS  fully carried, reduced binary result (< P).
REQ-008 o_val  output  1  o_dat valid; held until accepted.
REQ-009 i_rdy  input  1  consumer accept; transfer occurs on o_val && i_rdy.
REQ-010 o_ovrn  output  1  sticky: an i_val arrived while o_busy was high.
REQ-011 o_err  output  1  sticky: value was still >= P after the final subtraction pass.

Function
REQ-012 FSM states SHALL be one-hot: IDLE, CARRY, SUB, OUT.
REQ-013 IDLE: i_val SHALL capture i_mul into the working register, clear the word index and carry, and go to CARRY on the next edge.
REQ-014 CARRY: one word per cycle, index 0..NUM_WRDS-1:
- word[i] <= (word[i][WRD_BITS-1:0] + c) mod 2^WRD_BITS
- c <= word[i][WRD_BITS] + overflow of that sum (c is 2 bits)
- after word NUM_WRDS-1, the final c SHALL be stored in an extra top word X[NUM_WRDS]
- then go to SUB with pass count 0.
REQ-015 SUB: word-serial X - P over NUM_WRDS+1 words, with P zero-extended and the borrow held in a 1-bit register.
- Differences SHALL go to a shadow register.
- At pass end, if the final borrow is 0, X SHALL take the shadow value; otherwise X is unchanged.
- Exactly MAX_SUB passes SHALL always execute, whatever the data.
REQ-016 After the last pass: o_err SHALL be set if the last pass committed and X[NUM_WRDS] != 0 or X >= P. The state SHALL then become OUT.
REQ-017 OUT: o_val=1 and o_dat=X[NUM_WRDS-1:0], both stable until i_rdy.
- On acceptance: IDLE, with o_val low the next cycle.
REQ-018 Latency from the i_val capture edge to o_val high SHALL be exactly 1+NUM_WRDS+MAX_SUB*(NUM_WRDS+1) cycles, independent of data.
REQ-019 i_val while not IDLE SHALL be dropped and SHALL set o_ovrn; the in-flight result SHALL be unaffected.
REQ-020 i_val in the same cycle that OUT is accepted SHALL be treated as busy (dropped, o_ovrn set).
REQ-021 o_busy SHALL be high in CARRY, SUB and OUT.
REQ-022 Zero input SHALL yield o_dat=0 with no commit.
REQ-023 An input equal to P SHALL yield 0.

Reset
REQ-024 With i_rst_n low at an edge, the block SHALL enter IDLE and clear o_val, o_busy, o_ovrn, o_err, the index, the pass count and the carry/borrow, including mid-CARRY/SUB/OUT; any in-flight result is discarded.
REQ-025 Datapath registers (working, shadow, o_dat) SHALL NOT be reset; o_dat is don't-care while o_val=0.

Structure
REQ-026 MAX_SUB (value 2) and the one-hot state typedef SHALL be added to redun_mont_pkg; to_redun and redun0_t SHALL be reused from it.
REQ-027 One sub-module SHALL be used: redun_word_addsub, a single WRD_BITS add/subtract with carry/borrow in and out, instantiated once and shared by CARRY and SUB.
REQ-028 No wide (>2*WRD_BITS) carry chain SHALL exist.

Verification
Bench package override: WRD_BITS=16, NUM_WRDS=4, P=0xF123_4567_89AB_CDEF.

REQ-029 Binary input 0x0000_0000_0000_1234 with all carry bits 0 -> o_dat=0x0000_0000_0000_1234 at exactly 1+4+2*5=15 cycles.
REQ-030 Every word = 0x1FFFF (all carry bits set) -> o_dat = (redundant value mod P), matching the model; o_err=0.
REQ-031 Input = 2P-1 expressed redundantly -> o_dat=P-1. Input = P -> o_dat=0. Input = 2P -> o_dat=0.
REQ-032 i_rdy held low 20 cycles after o_val -> o_val and o_dat stable throughout; transfer on the first i_rdy=1 cycle; o_val low the next cycle.
REQ-033 Second i_val during SUB -> o_ovrn=1, first result correct, second discarded; i_rst_n low for 1 cycle -> o_ovrn=0, state IDLE.
REQ-034 Reset asserted mid-CARRY -> no o_val is produced; a new input after reset gives the correct result at 15 cycles.

Source files
------------

// File: rtl/redun_mont_pkg.sv
// Shared word geometry, modulus and types for the redundant Montgomery datapath.
// Includes the redundant-operand type, its binary conversion helper and the collapse FSM state encoding.
package redun_mont_pkg;

    localparam int WRD_BITS = 16;
    localparam int NUM_WRDS = 4;
    localparam logic [NUM_WRDS*WRD_BITS-1:0] P = 64'hF123_4567_89AB_CDEF;
    localparam int MAX_SUB  = 2;

    localparam int IDX_W  = $clog2(NUM_WRDS + 1);
    localparam int SIDX_W = $clog2(NUM_WRDS);
    localparam int PASS_W = $clog2(MAX_SUB + 1);

    // Word i carries weight 2^(i*WRD_BITS); its top bit is a carry of weight 2^((i+1)*WRD_BITS).
    typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_CARRY = 4'b0010,
        ST_SUB   = 4'b0100,
        ST_OUT   = 4'b1000
    } collapse_state_t;

    function automatic redun0_t to_redun(input logic [NUM_WRDS*WRD_BITS-1:0] b);
        redun0_t r;
        for (int i = 0; i < NUM_WRDS; i++) begin
            r[i] = {1'b0, b[i*WRD_BITS +: WRD_BITS]};
        end
        return r;
    endfunction

endpackage

// File: rtl/redun_word_addsub.sv
// Single word add (a+b+cin) or subtract (a-b-bin) with carry/borrow out.
// Purely combinational; no handshake.
module redun_word_addsub
    import redun_mont_pkg::*;
(
    input  logic [WRD_BITS-1:0] a_i,
    input  logic [WRD_BITS-1:0] b_i,
    input  logic                sub_i,
    input  logic                c_i,
    output logic [WRD_BITS-1:0] r_o,
    output logic                c_o
);

    logic [WRD_BITS:0] res;

    // In subtract mode bit WRD_BITS of the widened result is the borrow out.
    always_comb begin
        if (sub_i) begin
            res = {1'b0, a_i} - {1'b0, b_i} - {{WRD_BITS{1'b0}}, c_i};
        end else begin
            res = {1'b0, a_i} + {1'b0, b_i} + {{WRD_BITS{1'b0}}, c_i};
        end
    end

    assign r_o = res[WRD_BITS-1:0];
    assign c_o = res[WRD_BITS];

endmodule

// File: rtl/redun_collapse.sv
// Collapses a redundant squarer result to binary, then conditionally subtracts P MAX_SUB times, word-serially.
// Latency 1+NUM_WRDS+MAX_SUB*(NUM_WRDS+1) cycles from capture; o_val/o_dat held until i_rdy, new i_val while busy is dropped.
module redun_collapse
    import redun_mont_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  redun0_t                      i_mul,
    input  logic                         i_val,
    output logic                         o_busy,
    output logic [NUM_WRDS*WRD_BITS-1:0] o_dat,
    output logic                         o_val,
    input  logic                         i_rdy,
    output logic                         o_ovrn,
    output logic                         o_err
);

    localparam logic [NUM_WRDS:0][WRD_BITS-1:0] P_WORDS = {{WRD_BITS{1'b0}}, P};

    collapse_state_t                     state_q;
    logic [IDX_W-1:0]                    idx_q;
    logic [PASS_W-1:0]                   pass_q;
    logic [1:0]                          c_q;
    logic                                bor_q;
    logic                                ge_q;
    logic                                val_q;
    logic                                busy_q;
    logic                                ovrn_q;
    logic                                err_q;
    logic [NUM_WRDS:0][WRD_BITS:0]       work_q;
    logic [NUM_WRDS-1:0][WRD_BITS-1:0]   shd_q;

    logic [WRD_BITS:0]   cur_w;
    logic [WRD_BITS-1:0] as_a;
    logic [WRD_BITS-1:0] as_b;
    logic [WRD_BITS-1:0] as_r;
    logic                as_sub;
    logic                as_cin;
    logic                as_cout;
    logic [1:0]          c_d;
    logic                ge_d;
    logic                last_word;
    logic                last_pass;

    redun_word_addsub u_addsub (
        .a_i   (as_a),
        .b_i   (as_b),
        .sub_i (as_sub),
        .c_i   (as_cin),
        .r_o   (as_r),
        .c_o   (as_cout)
    );

    // ge tracks "difference so far >= P so far" LSB-first, so the final-pass check needs no wide comparator.
    always_comb begin
        cur_w     = work_q[idx_q];
        as_sub    = (state_q == ST_SUB);
        as_a      = cur_w[WRD_BITS-1:0];
        as_b      = as_sub ? P_WORDS[idx_q] : {{(WRD_BITS-2){1'b0}}, c_q};
        as_cin    = as_sub ? bor_q : 1'b0;
        c_d       = {1'b0, cur_w[WRD_BITS]} + {1'b0, as_cout};
        ge_d      = (as_r > P_WORDS[idx_q]) || ((as_r == P_WORDS[idx_q]) && ge_q);
        last_word = (idx_q == IDX_W'(NUM_WRDS));
        last_pass = (pass_q == PASS_W'(MAX_SUB - 1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            c_q     <= '0;
            bor_q   <= 1'b0;
            ge_q    <= 1'b1;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovrn_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (i_val && (state_q != ST_IDLE)) begin
                ovrn_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_val) begin
                        state_q <= ST_CARRY;
                        idx_q   <= '0;
                        c_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CARRY: begin
                    if (last_word) begin
                        state_q <= ST_SUB;
                        idx_q   <= '0;
                        pass_q  <= '0;
                        bor_q   <= 1'b0;
                        ge_q    <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        c_q   <= c_d;
                    end
                end
                ST_SUB: begin
                    if (last_word) begin
                        idx_q <= '0;
                        bor_q <= 1'b0;
                        ge_q  <= 1'b1;
                        if (last_pass) begin
                            err_q   <= err_q | (!as_cout && ge_d);
                            state_q <= ST_OUT;
                            val_q   <= 1'b1;
                        end else begin
                            pass_q <= pass_q + 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        bor_q <= as_cout;
                        ge_q  <= ge_d;
                    end
                end
                ST_OUT: begin
                    if (i_rdy) begin
                        state_q <= ST_IDLE;
                        val_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Datapath carries no reset; its contents only matter while the FSM says so.
    always_ff @(posedge i_clk) begin
        case (state_q)
            ST_IDLE: begin
                if (i_val) begin
                    for (int i = 0; i < NUM_WRDS; i++) begin
                        work_q[i] <= i_mul[i];
                    end
                    work_q[NUM_WRDS] <= '0;
                end
            end
            ST_CARRY: begin
                if (last_word) begin
                    work_q[NUM_WRDS] <= {{(WRD_BITS-1){1'b0}}, c_q};
                end else begin
                    work_q[idx_q] <= {1'b0, as_r};
                end
            end
            ST_SUB: begin
                if (!last_word) begin
                    shd_q[idx_q[SIDX_W-1:0]] <= as_r;
                end else if (!as_cout) begin
                    for (int i = 0; i < NUM_WRDS; i++) begin
                        work_q[i] <= {1'b0, shd_q[i]};
                    end
                    work_q[NUM_WRDS] <= {1'b0, as_r};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_WRDS; i++) begin
            o_dat[i*WRD_BITS +: WRD_BITS] = work_q[i][WRD_BITS-1:0];
        end
    end

    assign o_val  = val_q;
    assign o_busy = busy_q;
    assign o_ovrn = ovrn_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_redun_collapse.sv
// Directed self-checking bench for redun_collapse with hand-computed expectations.
module tb_redun_collapse;
    import redun_mont_pkg::*;

    logic                         i_clk;
    logic                         i_rst_n;
    redun0_t                      i_mul;
    logic                         i_val;
    logic                         o_busy;
    logic [NUM_WRDS*WRD_BITS-1:0] o_dat;
    logic                         o_val;
    logic                         i_rdy;
    logic                         o_ovrn;
    logic                         o_err;

    int checks = 0;
    int errors = 0;

    redun_collapse dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_mul   (i_mul),
        .i_val   (i_val),
        .o_busy  (o_busy),
        .o_dat   (o_dat),
        .o_val   (o_val),
        .i_rdy   (i_rdy),
        .o_ovrn  (o_ovrn),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Present v for one capture edge; returns #1 after that edge.
    task automatic send(input redun0_t v);
        @(negedge i_clk);
        i_mul = v;
        i_val = 1'b1;
        @(posedge i_clk);
        #1 i_val = 1'b0;
    endtask

    task automatic wait_val(input int budget, output int lat);
        lat = 0;
        while (!o_val && lat < budget) begin
            @(posedge i_clk);
            #1 lat++;
        end
    endtask

    task automatic accept();
        i_rdy = 1'b1;
        @(posedge i_clk);
        #1 i_rdy = 1'b0;
    endtask

    task automatic count_vals(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge i_clk);
            #1 if (o_val) seen++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (o_val !== 1'b0)  begin errors++; $display("FAIL rst_val got=%b exp=0", o_val); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        checks++; if (o_ovrn !== 1'b0) begin errors++; $display("FAIL rst_ovrn got=%b exp=0", o_ovrn); end
        checks++; if (o_err !== 1'b0)  begin errors++; $display("FAIL rst_err got=%b exp=0", o_err); end
    endtask

    task automatic test_passthrough();
        int lat;
        send(to_redun(64'h0000_0000_0000_1234));
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL pass_busy got=%b exp=1", o_busy); end
        wait_val(40, lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL pass_latency got=%0d exp=15", lat); end
        checks++; if (o_dat !== 64'h0000_0000_0000_1234) begin errors++; $display("FAIL pass_dat got=%h exp=0000000000001234", o_dat); end
        accept();
    endtask

    task automatic test_all_ones();
        redun0_t v;
        int lat;
        for (int i = 0; i < NUM_WRDS; i++) v[i] = 17'h1_FFFF;
        send(v);
        wait_val(40, lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL ones_latency got=%0d exp=15", lat); end
        checks++; if (o_dat !== 64'h1DBA_7531_ECA9_6421) begin errors++; $display("FAIL ones_dat got=%h exp=1dba7531eca96421", o_dat); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ones_err got=%b exp=0", o_err); end
        accept();
    endtask

    task automatic test_boundaries();
        redun0_t v [4];
        logic [63:0] exp [4];
        int lat;
        // 2P-1 with carries moved between words
        v[0][0] = 17'h1_9BDD; v[0][1] = 17'h0_1356; v[0][2] = 17'h0_8ACF; v[0][3] = 17'h1_E246;
        exp[0] = 64'hF123_4567_89AB_CDEE;
        v[1] = to_redun(64'hF123_4567_89AB_CDEF);
        exp[1] = 64'h0;
        v[2][0] = 17'h0_9BDE; v[2][1] = 17'h0_1357; v[2][2] = 17'h0_8ACF; v[2][3] = 17'h1_E246;
        exp[2] = 64'h0;
        v[3] = to_redun(64'h0);
        exp[3] = 64'h0;
        for (int t = 0; t < 4; t++) begin
            send(v[t]);
            wait_val(40, lat);
            checks++; if (lat !== 15) begin errors++; $display("FAIL bound%0d_latency got=%0d exp=15", t, lat); end
            checks++; if (o_dat !== exp[t]) begin errors++; $display("FAIL bound%0d_dat got=%h exp=%h", t, o_dat, exp[t]); end
            accept();
        end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL bound_err got=%b exp=0", o_err); end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        send(to_redun(64'h0123_4567_89AB_CDEF));
        wait_val(40, lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL bp_latency got=%0d exp=15", lat); end
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (o_val !== 1'b1 || o_dat !== 64'h0123_4567_89AB_CDEF) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL bp_hold cyc=%0d got val=%b dat=%h exp val=1 dat=0123456789abcdef", k, o_val, o_dat);
            end
            @(posedge i_clk);
            #1;
        end
        accept();
        checks++; if (o_val !== 1'b0) begin errors++; $display("FAIL bp_val_drop got=%b exp=0", o_val); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_busy_drop got=%b exp=0", o_busy); end
    endtask

    task automatic test_overrun();
        redun0_t v;
        int lat;
        int seen;
        for (int i = 0; i < NUM_WRDS; i++) v[i] = 17'h1_FFFF;
        send(v);
        repeat (8) @(posedge i_clk);
        #1 i_mul = to_redun(64'h5555); i_val = 1'b1;
        @(posedge i_clk);
        #1 i_val = 1'b0;
        checks++; if (o_ovrn !== 1'b1) begin errors++; $display("FAIL ovrn_set got=%b exp=1", o_ovrn); end
        wait_val(40, lat);
        checks++; if (lat + 9 !== 15) begin errors++; $display("FAIL ovrn_latency got=%0d exp=15", lat + 9); end
        checks++; if (o_dat !== 64'h1DBA_7531_ECA9_6421) begin errors++; $display("FAIL ovrn_dat got=%h exp=1dba7531eca96421", o_dat); end
        accept();
        count_vals(30, seen);
        checks++; if (seen !== 0) begin errors++; $display("FAIL ovrn_second got=%0d vals exp=0", seen); end
        do_reset();
        #1;
        checks++; if (o_ovrn !== 1'b0) begin errors++; $display("FAIL ovrn_clear got=%b exp=0", o_ovrn); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ovrn_idle_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_accept_collision();
        int lat;
        int seen;
        send(to_redun(64'h0000_0000_0000_00AA));
        wait_val(40, lat);
        checks++; if (o_dat !== 64'h0000_0000_0000_00AA) begin errors++; $display("FAIL coll_dat got=%h exp=00000000000000aa", o_dat); end
        i_mul = to_redun(64'h77);
        i_val = 1'b1;
        accept();
        i_val = 1'b0;
        checks++; if (o_ovrn !== 1'b1) begin errors++; $display("FAIL coll_ovrn got=%b exp=1", o_ovrn); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL coll_busy got=%b exp=0", o_busy); end
        count_vals(25, seen);
        checks++; if (seen !== 0) begin errors++; $display("FAIL coll_dropped got=%0d vals exp=0", seen); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        send(to_redun(64'h1111_2222_3333_4444));
        repeat (2) @(posedge i_clk);
        do_reset();
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
        count_vals(30, seen);
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_noval got=%0d vals exp=0", seen); end
        send(to_redun(64'h0FED_CBA9_8765_4321));
        wait_val(40, lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL midrst_latency got=%0d exp=15", lat); end
        checks++; if (o_dat !== 64'h0FED_CBA9_8765_4321) begin errors++; $display("FAIL midrst_dat got=%h exp=0fedcba987654321", o_dat); end
        accept();
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_mul   = '0;
        i_val   = 1'b0;
        i_rdy   = 1'b0;
        test_reset();
        test_passthrough();
        test_all_ones();
        test_boundaries();
        test_backpressure();
        test_overrun();
        test_accept_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
